// File: rtl/seg_pkg.sv
// Symbol codes and segment encoding shared by the seven-segment scan controller.
// Pure definitions: no latency, no flow control.
package seg_pkg;

    localparam logic [4:0] SYM_I     = 5'd10;
    localparam logic [4:0] SYM_G     = 5'd11;
    localparam logic [4:0] SYM_T     = 5'd12;
    localparam logic [4:0] SYM_A     = 5'd13;
    localparam logic [4:0] SYM_B     = 5'd14;
    localparam logic [4:0] SYM_C     = 5'd15;
    localparam logic [4:0] SYM_J     = 5'd16;
    localparam logic [4:0] SYM_DASH  = 5'd17;
    localparam logic [4:0] BLANK     = 5'd31;

    typedef enum logic {
        CONV_IDLE,
        CONV_RUN
    } conv_state_t;

    // Segment order g..a in bits 6..0, active high.
    function automatic logic [6:0] seg_encode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:     seg = 7'h3F;
            5'd1:     seg = 7'h06;
            5'd2:     seg = 7'h5B;
            5'd3:     seg = 7'h4F;
            5'd4:     seg = 7'h66;
            5'd5:     seg = 7'h6D;
            5'd6:     seg = 7'h7D;
            5'd7:     seg = 7'h07;
            5'd8:     seg = 7'h7F;
            5'd9:     seg = 7'h6F;
            SYM_I:    seg = 7'h30;
            SYM_G:    seg = 7'h3D;
            SYM_T:    seg = 7'h78;
            SYM_A:    seg = 7'h77;
            SYM_B:    seg = 7'h7C;
            SYM_C:    seg = 7'h39;
            SYM_J:    seg = 7'h1E;
            SYM_DASH: seg = 7'h40;
            default:  seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with overflow flag; VAL_W cycles per conversion.
// No backpressure: start restarts at any time, done is a one-cycle pulse with bcd/ovf valid alongside.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VAL_W    = 16,
    parameter int N_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(VAL_W);

    conv_state_t      state, state_nxt;
    logic [VAL_W-1:0] shreg;
    logic [BCD_W-1:0] acc, acc_adj, acc_nxt;
    logic             ovf_q, carry, last;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        // A bit leaving the top digit means the running prefix already reached 10^N_DIGITS.
        carry   = acc_adj[BCD_W-1];
        acc_nxt = {acc_adj[BCD_W-2:0], shreg[VAL_W-1]};
        last    = (state == CONV_RUN) && (cnt == CNT_W'(VAL_W - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= CONV_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            CONV_IDLE: if (start) state_nxt = CONV_RUN;
            CONV_RUN: begin
                if (start) begin
                    state_nxt = CONV_RUN;
                end else if (last) begin
                    state_nxt = CONV_IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            shreg <= bin;
            acc   <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
        end else if (state == CONV_RUN) begin
            shreg <= shreg << 1;
            acc   <= acc_nxt;
            ovf_q <= ovf_q | carry;
            cnt   <= cnt + 1'b1;
        end
    end

    assign busy = (state == CONV_RUN);
    assign bcd  = acc_nxt;
    assign ovf  = ovf_q | carry;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with BCD/raw display, blink, dp, PWM brightness and frame-synchronous commit.
// Outputs registered one cycle after scan counters; no backpressure, load may restart conversion at any time.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int VAL_W    = 16,
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_bin,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value,
    input  logic [5*N_DIGITS-1:0] raw_code,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [3:0]            bright,
    output logic                  busy,
    output logic [N_DIGITS-1:0]   seg_sel,
    output logic [7:0]            seg_data
);

    localparam int SCAN_DIV  = CLK_FREQ / (SCAN_HZ * N_DIGITS);
    localparam int SUB_DIV   = SCAN_DIV / 16;
    localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int SLOT_W    = $clog2(SCAN_DIV);
    localparam int IDX_W     = $clog2(N_DIGITS);
    localparam int BLK_W     = $clog2(BLINK_DIV + 1);

    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  blink_ph;
    logic                  slot_wrap, frame_start, blink_wrap;

    logic                  conv_done, conv_ovf;
    logic [4*N_DIGITS-1:0] conv_bcd;
    logic [4:0]            conv_code [N_DIGITS];
    logic [4:0]            pend      [N_DIGITS];
    logic [4:0]            disp_buf  [N_DIGITS];

    logic [3:0]            sub;
    logic [4:0]            cur_code;
    logic                  blanked;
    logic [N_DIGITS-1:0]   sel_onehot;

    bin2bcd_seq #(
        .VAL_W    (VAL_W),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (load),
        .bin   (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    assign slot_wrap   = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign frame_start = slot_wrap && (scan_idx == IDX_W'(N_DIGITS - 1));
    assign blink_wrap  = (blink_cnt == BLK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            scan_idx  <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                scan_idx <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end
            blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            if (blink_wrap) blink_ph <= ~blink_ph;
        end
    end

    // Leading-zero suppression scans from the top digit down; digit 0 is always shown.
    always_comb begin
        logic       seen;
        logic [3:0] digit;
        seen  = 1'b0;
        digit = 4'd0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            digit = conv_bcd[4*i +: 4];
            if (digit != 4'd0 || i == 0) seen = 1'b1;
            if (conv_ovf)  conv_code[i] = SYM_DASH;
            else if (seen) conv_code[i] = {1'b0, digit};
            else           conv_code[i] = BLANK;
        end
    end

    // Commit reads the old pending value when completion and frame start share an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                pend[i]     <= BLANK;
                disp_buf[i] <= BLANK;
            end
        end else begin
            if (conv_done) begin
                for (int i = 0; i < N_DIGITS; i++) pend[i] <= conv_code[i];
            end
            if (frame_start) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    disp_buf[i] <= mode_bin ? pend[i] : raw_code[5*i +: 5];
                end
            end
        end
    end

    always_comb begin
        sub        = 4'(slot_cnt / SLOT_W'(SUB_DIV));
        cur_code   = disp_buf[scan_idx];
        blanked    = blink_mask[scan_idx] & ~blink_ph;
        sel_onehot = '0;
        sel_onehot[scan_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_sel  <= '0;
            seg_data <= '0;
        end else begin
            seg_sel  <= '0;
            seg_data <= '0;
            if (sub < bright) begin
                seg_sel <= sel_onehot;
                if (!blanked) seg_data <= {dp_mask[scan_idx], seg_encode(cur_code)};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: frame-by-frame directed vectors push expected digit windows and busy pulse lengths;
// a monitor measures what the display actually shows and pops/compares.
module tb_seg_scan_ctrl;

    localparam logic [19:0] RAW_BLANK = {5'd31, 5'd31, 5'd31, 5'd31};
    localparam logic [19:0] RAW_A     = {5'd13, 5'd31, 5'd31, 5'd2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode_bin = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [19:0] raw_code = RAW_BLANK;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  bright = 4'd15;
    logic        busy;
    logic [3:0]  seg_sel;
    logic [7:0]  seg_data;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] dat;
        int         on;
    } win_t;

    win_t exp_q[$];
    int   busy_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .N_DIGITS (4),
        .VAL_W    (16),
        .CLK_FREQ (64000),
        .SCAN_HZ  (1000),
        .BLINK_HZ (500)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_bin   (mode_bin),
        .load       (load),
        .value      (value),
        .raw_code   (raw_code),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .bright     (bright),
        .busy       (busy),
        .seg_sel    (seg_sel),
        .seg_data   (seg_data)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One 64-cycle frame. Entered just before the frame's first scan edge.
    // e0..e3 are the bytes this frame must show; raw/mode feed the commit at its end.
    task automatic step(input logic mb, input logic [19:0] raw, input logic [3:0] dp,
                        input logic [3:0] blk, input logic [3:0] br, input int ld1, input int ld2,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                        input logic [7:0] e3);
        logic [7:0] e [4];
        win_t       w;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        mode_bin   = mb;
        raw_code   = raw;
        dp_mask    = dp;
        blink_mask = blk;
        bright     = br;
        if (br != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                w.sel    = '0;
                w.sel[i] = 1'b1;
                w.dat    = e[i];
                w.on     = int'(br);
                exp_q.push_back(w);
            end
        end
        if (ld1 >= 0) begin
            load  = 1'b1;
            value = 16'(ld1);
            busy_q.push_back(ld2 >= 0 ? 24 : 16);
        end
        @(posedge clk);
        #1 load = 1'b0;
        for (int k = 1; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (k == 7 && ld2 >= 0) begin
                load  = 1'b1;
                value = 16'(ld2);
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin : stimulus
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, RAW_BLANK, 4'b0000, 4'b0000, 4'd15, -1,    -1, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, RAW_BLANK, 4'b0000, 4'b0000, 4'd15, 1234,  -1, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, RAW_BLANK, 4'b0000, 4'b0000, 4'd15, 7,     -1, 8'h66, 8'h4F, 8'h5B, 8'h06);
        step(1'b1, RAW_BLANK, 4'b0000, 4'b0000, 4'd15, 0,     -1, 8'h07, 8'h00, 8'h00, 8'h00);
        step(1'b1, RAW_BLANK, 4'b0000, 4'b0000, 4'd15, 10000, -1, 8'h3F, 8'h00, 8'h00, 8'h00);
        step(1'b0, RAW_A,     4'b0000, 4'b0000, 4'd15, -1,    -1, 8'h40, 8'h40, 8'h40, 8'h40);
        step(1'b0, RAW_A,     4'b0000, 4'b1000, 4'd15, -1,    -1, 8'h5B, 8'h00, 8'h00, 8'h77);
        step(1'b0, RAW_A,     4'b0000, 4'b1000, 4'd15, -1,    -1, 8'h5B, 8'h00, 8'h00, 8'h00);
        step(1'b0, RAW_A,     4'b0010, 4'b1000, 4'd15, -1,    -1, 8'h5B, 8'h80, 8'h00, 8'h77);
        step(1'b0, RAW_A,     4'b1001, 4'b1000, 4'd15, -1,    -1, 8'hDB, 8'h00, 8'h00, 8'h00);
        step(1'b0, RAW_A,     4'b0000, 4'b0000, 4'd4,  -1,    -1, 8'h5B, 8'h00, 8'h00, 8'h77);
        step(1'b1, RAW_A,     4'b0000, 4'b0000, 4'd0,  500,   42, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, RAW_A,     4'b0000, 4'b0000, 4'd15, -1,    -1, 8'h5B, 8'h66, 8'h00, 8'h00);
        step(1'b1, RAW_A,     4'b0000, 4'b0000, 4'd15, -1,    -1, 8'h5B, 8'h66, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("windows_left", exp_q.size(), 0);
        check("busy_pulses_left", busy_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : monitor
        logic       in_win;
        logic       stable;
        int         on_cnt;
        int         busy_len;
        logic [3:0] w_sel;
        logic [7:0] w_dat;
        win_t       w;
        in_win   = 1'b0;
        stable   = 1'b1;
        on_cnt   = 0;
        busy_len = 0;
        w_sel    = '0;
        w_dat    = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_seg_sel", int'(seg_sel), 0);
                check("rst_seg_data", int'(seg_data), 0);
                check("rst_busy", int'(busy), 0);
            end else begin
                if (busy) begin
                    busy_len++;
                end else if (busy_len > 0) begin
                    if (busy_q.size() == 0) check("busy_unexpected", busy_len, 0);
                    else                    check("busy_len", busy_len, busy_q.pop_front());
                    busy_len = 0;
                end
                if (seg_sel != 4'b0000) begin
                    if (!in_win) begin
                        in_win = 1'b1;
                        stable = 1'b1;
                        on_cnt = 1;
                        w_sel  = seg_sel;
                        w_dat  = seg_data;
                    end else begin
                        on_cnt++;
                        if (seg_sel != w_sel || seg_data != w_dat) stable = 1'b0;
                    end
                end else begin
                    check("idle_seg_data", int'(seg_data), 0);
                    if (in_win) begin
                        in_win = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("win_unexpected", on_cnt, 0);
                        end else begin
                            w = exp_q.pop_front();
                            check("win_sel", int'(w_sel), int'(w.sel));
                            check("win_data", int'(w_dat), int'(w.dat));
                            check("win_on_cycles", on_cnt, w.on);
                            check("win_stable", int'(stable), 1);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: end of stimulus not reached, elapsed %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment controller for N common-cathode digits, the successor of the fixed 4-digit display driver. It shows either a binary value (converted on-chip to BCD, with leading-zero suppression and overflow indication) or per-digit raw symbol codes. It adds per-digit blink and decimal point, global PWM brightness and tear-free frame-synchronous updates. It sits between the calculator FSM/countdown logic and the board's `seg_sel`/`seg_data` pins.

## Interface
- `N_DIGITS`, default 8: number of digits, 2..8.
- `VAL_W`, default 16: width of the binary input value, 4..27.
- `CLK_FREQ`, default 100_000_000: system clock in Hz.
- `SCAN_HZ`, default 1000: full-frame refresh rate in Hz.
- `BLINK_HZ`, default 2: blink rate in Hz.
- `clk`  in  1: system clock. Single clock domain.
- `rst_n`  in  1: reset, synchronous, active-low.
- `mode_bin`  in  1: 1 displays `value` in decimal; 0 displays the `raw_code` symbols.
- `load`  in  1: single-cycle pulse that starts BCD conversion of `value`.
- `value`  in  VAL_W: unsigned binary value, sampled on `load`.
- `raw_code`  in  5*N_DIGITS: 5-bit symbol per digit; digit 0 is the rightmost and uses bits [4:0].
- `dp_mask`  in  N_DIGITS: decimal point per digit.
- `blink_mask`  in  N_DIGITS: blink enable per digit.
- `bright`  in  4: duty level, 0 = off, 15 = 15/16.
- `busy`  out  1: conversion in progress.
- `seg_sel`  out  N_DIGITS: one-hot digit enable, active high.
- `seg_data`  out  8: segment lines, active high, bit 7 = dp, bits 6..0 = g..a.

## Operation
- Symbol codes:
  - 0–9 are digits.
  - 10 'I', 11 'G', 12 'T', 13 'A', 14 'b', 15 'C', 16 'J', 17 '-'.
  - 31 and every other unlisted code are blank.
  - Segment patterns match the existing calculator display.
- Scan:
  - `SCAN_DIV = CLK_FREQ/(SCAN_HZ*N_DIGITS)`, which must be a multiple of 16 and at least 16.
  - `slot_cnt` counts 0..SCAN_DIV-1. When it wraps, `scan_idx` advances 0..N_DIGITS-1 and then returns to 0.
  - A frame starts each time `scan_idx` wraps to 0.
- Brightness: `sub = slot_cnt / (SCAN_DIV/16)`. The digit is driven only while `sub < bright`; otherwise `seg_sel` is 0 and `seg_data` is 0.
- Blink:
  - `blink_ph` toggles every `CLK_FREQ/(2*BLINK_HZ)` cycles.
  - While `blink_ph` = 0 (off half), digits whose `blink_mask` bit is set are blanked, including their dp.
- Binary path:
  - Conversion is shift-add-3 with one bit per cycle, so it takes VAL_W cycles.
  - A `load` while `busy` restarts conversion using the new `value`.
  - If `value` > 10^N_DIGITS − 1, the result is overflow and all digits show '-'.
  - Leading-zero suppression: digits above the highest non-zero digit are blank. Value 0 shows a single '0' on digit 0.
- Display buffer, N_DIGITS×5 bits:
  - Committed only at frame start.
  - When `mode_bin` = 0, the commit copies `raw_code`.
  - When `mode_bin` = 1, the commit copies the last completed conversion result, held in a pending register.
  - A conversion that finishes mid-frame is shown from the next frame.
  - `dp_mask` and `blink_mask` are sampled live.

## Timing
- Reset values:
  - Outputs: `seg_sel` = 0, `seg_data` = 0, `busy` = 0.
  - Counters and index: `scan_idx` = 0, `slot_cnt` = 0, blink counter = 0.
  - `blink_ph` = 1 (on).
  - Buffer and pending register: all 31 (blank).
- Output latency: `seg_sel`/`seg_data` are registered and reflect `scan_idx`/`sub` one cycle after they change.
- `busy` rises the cycle after `load` and falls after VAL_W cycles. The pending register updates on the same edge on which `busy` falls.
- Simultaneous events:
  - If `load` arrives on the cycle conversion completes, that result is discarded and the restart wins.
  - If a frame start coincides with completion, the old pending value is committed.
- Reset mid-conversion aborts it. The display blanks and stays blank until the next committed frame.
- Changing `mode_bin` takes effect at the next frame start.

## Structure
- `seg_pkg` holds:
  - the symbol code constants;
  - function `seg_encode(code[4:0]) -> [6:0]`;
  - `BLANK` = 5'd31.
- Sub-module `bin2bcd_seq` (VAL_W, N_DIGITS):
  - inputs: start, bin;
  - outputs: busy, done pulse, bcd[4*N_DIGITS-1:0], ovf.
- Top level contains the scan/PWM counters, blink timer, zero suppression, buffer commit and output registers.

## Test plan
All scenarios use N_DIGITS=4, VAL_W=16, CLK_FREQ=64000, SCAN_HZ=1000, BLINK_HZ=500. With these values SCAN_DIV=16, one PWM sub-phase is one cycle, and one blink half-period is 64 cycles (one frame).
- Reset, then release with `bright`=15 and `mode_bin`=0, `raw_code`={31,31,31,31} → `seg_sel`=0 and `seg_data`=0 during reset; afterwards `seg_data` stays 0 and `seg_sel` walks 0001→0010→0100→1000 for 15 of every 16 cycles.
- `mode_bin`=1, `load` with `value`=1234 → `busy` high for exactly 16 cycles; from the next frame the digits read 4,3,2,1 (0x66, 0x4F, 0x5B, 0x06 on digits 0..3).
- `value`=7 → digit 0 = 0x07 and digits 1–3 blank. `value`=0 → digit 0 = 0x3F. `value`=10000 → all digits 0x40 ('-').
- `raw_code`={'A',31,31,2} with `blink_mask`=4'b1000 → digit 3 = 0x77 in alternate frames and blank in the others; digit 0 = 0x5B in every frame.
- `bright`=4 → each digit is driven for 4 of its 16 cycles. `bright`=0 → `seg_sel` is never non-zero.
- `load` with 500, then `load` with 42 eight cycles later → `busy` stays high through 16 cycles after the second load; 500 is never displayed, and 42 is displayed.
